// File: rtl/shift_pkg.sv
// Shared definitions for the parallel/serial shift chain.
// Holds the shifter state encoding and the default word width.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/parallel_to_serial_shifter.sv
// Parallel-in, serial-out shifter with valid/ready load and a one-word
// holding buffer so frames can run back to back without an idle cycle.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   din        : parallel word, sampled only on accept
//   din_valid  : din is valid this cycle
//   din_ready  : word accepted this cycle if din_valid (0 while rst)
//   q          : registered serial bit, 0 when not shifting
//   q_valid    : q carries a frame bit
//   q_first    : first bit of a frame
//   q_last     : last bit of a frame
//   busy       : a frame is in progress
module parallel_to_serial_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             q_valid,
    output logic             q_first,
    output logic             q_last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_cnt;
    logic             r_q;
    logic             r_q_valid;
    logic             r_q_first;
    logic             r_q_last;
    logic             r_busy;

    logic             w_accept;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;

    // Bit that goes out first for a freshly loaded word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // r_shreg keeps the current bit at its head; the following bit is
    // the one adjacent to the head.
    always_comb begin
        din_ready  = !rst && ((r_state == IDLE) || !r_hold_full);
        w_accept   = din_valid && din_ready;
        w_next_bit = MSB_FIRST ? r_shreg[WIDTH-2] : r_shreg[1];
        w_shifted  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_q         <= 1'b0;
            r_q_valid   <= 1'b0;
            r_q_first   <= 1'b0;
            r_q_last    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= SHIFT;
                        r_shreg   <= din;
                        r_cnt     <= '0;
                        r_q       <= head_bit(din);
                        r_q_valid <= 1'b1;
                        r_q_first <= 1'b1;
                        r_q_last  <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_cnt == LAST_CNT) begin
                        // Last-bit edge: chain the next frame if one is
                        // available, otherwise drop back to idle.
                        if (r_hold_full) begin
                            r_shreg     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_cnt       <= '0;
                            r_q         <= head_bit(r_hold);
                            r_q_first   <= 1'b1;
                            r_q_last    <= 1'b0;
                        end else if (w_accept) begin
                            r_shreg   <= din;
                            r_cnt     <= '0;
                            r_q       <= head_bit(din);
                            r_q_first <= 1'b1;
                            r_q_last  <= 1'b0;
                        end else begin
                            r_state   <= IDLE;
                            r_shreg   <= w_shifted;
                            r_cnt     <= '0;
                            r_q       <= 1'b0;
                            r_q_valid <= 1'b0;
                            r_q_first <= 1'b0;
                            r_q_last  <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end else begin
                        r_shreg   <= w_shifted;
                        r_cnt     <= r_cnt + CW'(1);
                        r_q       <= w_next_bit;
                        r_q_first <= 1'b0;
                        r_q_last  <= (r_cnt == PRE_LAST);
                        if (w_accept) begin
                            r_hold      <= din;
                            r_hold_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign q_first = r_q_first;
    assign q_last  = r_q_last;
    assign busy    = r_busy;

endmodule

// File: tb/tb_parallel_to_serial_shifter.sv
// Self-checking bench for parallel_to_serial_shifter (WIDTH=4).
// Drives an MSB-first and an LSB-first instance against a bit-queue model.
module tb_parallel_to_serial_shifter;

    logic       clk;
    logic       rst;
    logic [3:0] d0, d1;
    logic       v0, v1;
    logic       rdy0, rdy1;
    logic       q0, qv0, qf0, ql0, b0;
    logic       q1, qv1, qf1, ql1, b1;

    parallel_to_serial_shifter #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(d0), .din_valid(v0), .din_ready(rdy0),
        .q(q0), .q_valid(qv0), .q_first(qf0), .q_last(ql0), .busy(b0)
    );

    parallel_to_serial_shifter #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(d1), .din_valid(v1), .din_ready(rdy1),
        .q(q1), .q_valid(qv1), .q_first(qf1), .q_last(ql1), .busy(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: every accepted word becomes four {bit,first,last} records
    // queued in send order; one record goes out per clock.
    logic [2:0] mq0[$];
    logic [2:0] mq1[$];
    logic [3:0] cur0, cur1;   // {bit, valid, first, last} of current cycle
    logic [3:0] chain0;       // serial-in receiver fed from q0
    logic       acc0_seen;
    int         total, bad;

    task automatic tick();
        logic       a0, a1;
        logic [2:0] r;
        a0 = v0 && !rst && (mq0.size() < 4);
        a1 = v1 && !rst && (mq1.size() < 4);
        if (qv0) chain0 = {chain0[2:0], q0};
        @(posedge clk);
        if (rst) begin
            mq0.delete();
            mq1.delete();
            cur0 = '0;
            cur1 = '0;
        end else begin
            if (a0)
                for (int k = 0; k < 4; k++)
                    mq0.push_back({d0[3-k], k == 0, k == 3});
            if (a1)
                for (int k = 0; k < 4; k++)
                    mq1.push_back({d1[k], k == 0, k == 3});
            cur0 = '0;
            cur1 = '0;
            if (mq0.size() > 0) begin
                r = mq0.pop_front();
                cur0 = {r[2], 1'b1, r[1], r[0]};
            end
            if (mq1.size() > 0) begin
                r = mq1.pop_front();
                cur1 = {r[2], 1'b1, r[1], r[0]};
            end
        end
        acc0_seen = a0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        tick();
        tick();
        total++;
        if ({q0, qv0, qf0, ql0, b0, rdy0, q1, qv1, qf1, ql1, b1, rdy1} !== 12'b0) begin
            bad++;
            $display("FAIL reset_state: got %b%b%b%b%b%b %b%b%b%b%b%b want all 0",
                     q0, qv0, qf0, ql0, b0, rdy0, q1, qv1, qf1, ql1, b1, rdy1);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({q0, qv0, b0, rdy0, rdy1} !== 5'b00011) begin
            bad++;
            $display("FAIL reset_release: got q=%b qv=%b busy=%b rdy=%b/%b want 0 0 0 1/1",
                     q0, qv0, b0, rdy0, rdy1);
        end
    endtask

    task automatic test_single();
        logic [4:0] e0, e1;
        e0 = 5'b10110;
        e1 = 5'b11010;
        d0 = 4'b1011; d1 = 4'b1011;
        v0 = 1'b1; v1 = 1'b1;
        tick();
        v0 = 1'b0; v1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            total++;
            if ({q0, qv0, qf0, ql0, b0} !== {e0[5-c], c <= 4, c == 1, c == 4, c <= 4}) begin
                bad++;
                $display("FAIL single_msb c%0d: got %b%b%b%b%b want %b%b%b%b%b", c,
                         q0, qv0, qf0, ql0, b0, e0[5-c], c <= 4, c == 1, c == 4, c <= 4);
            end
            total++;
            if ({q1, qv1, qf1, ql1, b1} !== {e1[5-c], c <= 4, c == 1, c == 4, c <= 4}) begin
                bad++;
                $display("FAIL single_lsb c%0d: got %b%b%b%b%b want %b%b%b%b%b", c,
                         q1, qv1, qf1, ql1, b1, e1[5-c], c <= 4, c == 1, c == 4, c <= 4);
            end
            tick();
        end
    endtask

    task automatic test_loopback();
        logic [3:0] w[2];
        int         n;
        w[0] = 4'b1011;
        w[1] = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            chain0 = '0;
            d0 = w[i];
            v0 = 1'b1;
            tick();
            v0 = 1'b0;
            n = 0;
            while (!ql0 && n < 10) begin
                total++;
                if ({q0, qv0, qf0, ql0} !== cur0) begin
                    bad++;
                    $display("FAIL loopback_stream: got %b%b%b%b want %b",
                             q0, qv0, qf0, ql0, cur0);
                end
                tick();
                n++;
            end
            tick();
            total++;
            if (n >= 10 || chain0 !== w[i]) begin
                bad++;
                $display("FAIL loopback_word: got %b want %b (cycles %0d)",
                         chain0, w[i], n);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  w[3];
        logic [11:0] stream;
        int          idx, nbits, run, maxrun, lowrdy;
        w[0] = 4'b1011; w[1] = 4'b0110; w[2] = 4'b1111;
        idx = 0; nbits = 0; run = 0; maxrun = 0; lowrdy = 0;
        stream = '0;
        d0 = w[0];
        v0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            total++;
            if ({q0, qv0, qf0, ql0, b0, rdy0} !==
                {cur0, cur0[2], !rst && (mq0.size() < 4)}) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got %b%b%b%b%b%b want %b%b%b", c,
                         q0, qv0, qf0, ql0, b0, rdy0, cur0, cur0[2],
                         !rst && (mq0.size() < 4));
            end
            if (qv0) begin
                stream = {stream[10:0], q0};
                nbits++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (!rdy0) lowrdy++;
            tick();
            if (acc0_seen) begin
                idx++;
                if (idx < 3) d0 = w[idx];
                else v0 = 1'b0;
            end
        end
        total++;
        if (stream !== 12'b1011_0110_1111 || nbits != 12) begin
            bad++;
            $display("FAIL b2b_stream: got %b (%0d bits) want 101101101111 (12 bits)",
                     stream, nbits);
        end
        total++;
        if (maxrun != 12) begin
            bad++;
            $display("FAIL b2b_continuous: got run %0d want 12", maxrun);
        end
        total++;
        if (lowrdy == 0) begin
            bad++;
            $display("FAIL b2b_ready_low: got %0d low cycles want >0", lowrdy);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        d0 = 4'b1011;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        n = 0;
        while (!ql0 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (n >= 10 || !rdy0) begin
            bad++;
            $display("FAIL simul_last_ready: got rdy=%b after %0d cycles want 1",
                     rdy0, n);
        end
        d0 = 4'b0101;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        total++;
        if ({q0, qv0, qf0, ql0} !== 4'b0110) begin
            bad++;
            $display("FAIL simul_first: got %b%b%b%b want 0110", q0, qv0, qf0, ql0);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({q0, qv0, qf0, ql0, b0} !== {cur0, cur0[2]}) begin
                bad++;
                $display("FAIL simul_tail c%0d: got %b%b%b%b%b want %b%b", c,
                         q0, qv0, qf0, ql0, b0, cur0, cur0[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        e = 5'b10010;
        d0 = 4'b1100;
        v0 = 1'b1;
        tick();
        d0 = 4'b1111;
        tick();
        v0 = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if ({q0, qv0, qf0, ql0, b0, rdy0} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid: got %b%b%b%b%b%b want 000000",
                     q0, qv0, qf0, ql0, b0, rdy0);
        end
        rst = 1'b0;
        d0 = 4'b1001;
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            total++;
            if ({q0, qv0, qf0, ql0} !== {e[5-c], c <= 4, c == 1, c == 4}) begin
                bad++;
                $display("FAIL reset_after c%0d: got %b%b%b%b want %b%b%b%b", c,
                         q0, qv0, qf0, ql0, e[5-c], c <= 4, c == 1, c == 4);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = (c < 380) && ($urandom_range(0, 59) == 0);
            v0 = (c < 370) && ($urandom_range(0, 3) != 0);
            v1 = (c < 370) && ($urandom_range(0, 2) != 0);
            d0 = 4'($urandom);
            d1 = 4'($urandom);
            tick();
            total++;
            if ({q0, qv0, qf0, ql0, b0} !== {cur0, cur0[2]}) begin
                bad++;
                $display("FAIL rand_msb c%0d: got %b%b%b%b%b want %b%b", c,
                         q0, qv0, qf0, ql0, b0, cur0, cur0[2]);
            end
            total++;
            if ({q1, qv1, qf1, ql1, b1} !== {cur1, cur1[2]}) begin
                bad++;
                $display("FAIL rand_lsb c%0d: got %b%b%b%b%b want %b%b", c,
                         q1, qv1, qf1, ql1, b1, cur1, cur1[2]);
            end
            total++;
            if ({rdy0, rdy1} !== {!rst && (mq0.size() < 4), !rst && (mq1.size() < 4)}) begin
                bad++;
                $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, rdy0, rdy1,
                         !rst && (mq0.size() < 4), !rst && (mq1.size() < 4));
            end
        end
        rst = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        chain0 = '0;
        cur0 = '0;
        cur1 = '0;
        acc0_seen = 1'b0;
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        d0 = '0; d1 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_loopback();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
